fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of `asyn_fifo_top` among `NUM_REQ` requesters in the write clock domain. Each requester offers data with a req/gnt handshake. The arbiter grants one owner at a time for bursts of up to `BURST_LEN` beats and drives `winc`/`wdata` directly from the granted requester. It never issues a write while `wfull` is high.

## Interface

Parameters:
- `DATA_WD`, default 8: data width per beat; matches the FIFO `DATA_WD`.
- `NUM_REQ`, default 4: number of requesters, ≥ 2.
- `BURST_LEN`, default 4: maximum beats per grant, ≥ 1.
- `OWNER_WD`, default `$clog2(NUM_REQ)`: width of the owner index.
- `CNT_WD`, default `$clog2(BURST_LEN+1)`: width of the beat counter.

Ports:
- `clk`, input, 1: write-domain clock; the same clock as the FIFO `wclk`.
- `rst`, input, 1: asynchronous reset, active-high.
- `req`, input, `NUM_REQ`: `req[i]` high means requester i has a beat on offer.
- `req_data`, input, `NUM_REQ*DATA_WD`: slice `[i*DATA_WD +: DATA_WD]` carries requester i's beat.
- `gnt`, output, `NUM_REQ`: one-hot or zero; a beat transfers when `req[i] && gnt[i]`.
- `wfull`, input, 1: full flag from the FIFO.
- `winc`, output, 1: FIFO write enable.
- `wdata`, output, `DATA_WD`: FIFO write data.
- `busy`, output, 1: high while in BURST.
- `owner`, output, `OWNER_WD`: index of the current or most recent owner.

## Operation

States:
- IDLE: no grant is issued.
  - If `|req`, search round-robin starting at `last_owner+1` (mod `NUM_REQ`) and pick the first requester with `req` set.
  - Register it into `owner`, clear `beat_cnt`, and move to BURST.
  - If no `req` is set, stay in IDLE.
- BURST:
  - `gnt[owner] = req[owner] && !wfull`; all other `gnt` bits are 0.
  - A transfer is `req[owner] && gnt[owner]`. On each transfer, `beat_cnt` increments.
  - Leave to IDLE when either:
    - a transfer occurs with `beat_cnt == BURST_LEN-1` (the last beat), or
    - `req[owner]` is low in that cycle (no transfer happens).
  - When `wfull` is high and `req[owner]` is high: stall. Stay in BURST with `beat_cnt` held, and keep `gnt` and `winc` at 0.
  - On every exit to IDLE, set `last_owner <= owner`.

Datapath (combinational, no added latency):
- `winc = |(req & gnt)`.
- `wdata = req_data` slice selected by `owner`. `wdata` is don't-care when `winc = 0` but must be stable and free of X after reset.
- Requesters may change `req_data` only after a transfer. Withdrawing `req` before it is granted is legal.

Reset values (asynchronous, while `rst` is high):
- State = IDLE, `gnt = 0`, `winc = 0`, `busy = 0`, `beat_cnt = 0`.
- `owner = 0`, `last_owner = NUM_REQ-1`, so requester 0 has first priority.
- Reset asserted mid-burst: the burst is abandoned and no partial-beat write occurs.

Boundary rules:
- `BURST_LEN = 1`: every grant is exactly one beat, then IDLE.
- Pointer wrap: after owner `NUM_REQ-1`, the search restarts at 0.
- A single active requester is re-granted after one IDLE bubble.
- `wfull` rising in the same cycle as the last beat: no transfer; stay in BURST until `wfull` falls.

## Timing

- One IDLE arbitration cycle precedes every burst: with `req` rising at edge N, the earliest transfer is in the cycle after edge N+1.
- Burst throughput is one beat per `clk` while `!wfull`.
- `gnt` and `winc` follow `wfull` and `req` combinationally within the cycle. The FIFO's registered `wfull` keeps this loop free of combinational cycles.
- Each burst is followed by exactly one IDLE bubble, so sustained throughput is `BURST_LEN/(BURST_LEN+1)`.
- `owner` and `busy` are registered and change at the IDLE→BURST edge.

## Test plan

All scenarios use `NUM_REQ=4`, `BURST_LEN=4`, `DATA_WD=8`.

1. Single requester: `req[2]` held high, `req_data` slice 2 advancing 0x10, 0x11, … after each transfer. Required: one IDLE cycle, then 4 cycles with `gnt=4'b0100`, `winc=1`, `wdata` = 0x10–0x13. Then one bubble, then 0x14–0x17.
2. All four requesting continuously: grant order 0, 1, 2, 3, 0, with 4 beats each and a one-cycle bubble between bursts. `owner` sequence is 0, 1, 2, 3, 0.
3. `wfull` high for 3 cycles after 2 beats of owner 1: `gnt` and `winc` stay 0 for those 3 cycles and `beat_cnt` holds at 2. Exactly 2 more beats follow, for 4 writes in total.
4. Owner 0 drops `req` after 1 beat while `req[3]` is high: BURST→IDLE in the next cycle, then owner = 3 (not 1 or 2, whose `req` is low).
5. `rst` pulsed mid-burst of owner 2: `gnt` and `winc` go to 0 asynchronously and `busy=0`. After release with all `req` high, the first grant goes to requester 0.
6. `BURST_LEN=1` build with `req=4'b1010`: single beats alternate between owners 1 and 3, each separated by one bubble.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Each grant covers a burst of up to BURST_LEN beats, stalled while wfull is high.
module fifo_wr_arbiter #(
    parameter int DATA_WD   = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4,
    parameter int OWNER_WD  = $clog2(NUM_REQ),
    parameter int CNT_WD    = $clog2(BURST_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_WD-1:0] req_data,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       wfull,
    output logic                       winc,
    output logic [DATA_WD-1:0]         wdata,
    output logic                       busy,
    output logic [OWNER_WD-1:0]        owner
);

    // Handshake: req[i] is the valid and gnt[i] is the ready for requester i.
    // A beat moves only in a cycle where both are high; that beat is the FIFO write.
    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic [OWNER_WD-1:0] owner_q, owner_d;
    logic [OWNER_WD-1:0] last_q, last_d;
    logic [OWNER_WD-1:0] pick;
    logic                found;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;

    // First requester after the previous owner, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = OWNER_WD'(idx);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == BURST) begin
            gnt[owner_q] = req[owner_q] && !wfull;
        end
    end

    assign winc  = |(req & gnt);
    assign busy  = (state_q == BURST);
    assign owner = owner_q;

    // Owner is always valid, so the mux never selects an undriven slice.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OWNER_WD'(i)) begin
                wdata = req_data[i*DATA_WD +: DATA_WD];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (winc) begin
                    if (cnt_q == CNT_WD'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end else begin
                        cnt_d = cnt_q + CNT_WD'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OWNER_WD'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a transaction-level model.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BL = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NR-1:0]  req = '0;
    logic [NR-1:0]  req2 = '0;
    logic           wfull = 1'b0;
    logic [DW-1:0]  dat [NR];
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  gnt, gnt2;
    logic           winc, winc2;
    logic [DW-1:0]  wdata, wdata2;
    logic           busy, busy2;
    logic [1:0]     owner, owner2;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q[$];

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    fifo_wr_arbiter #(.DATA_WD(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy), .owner(owner)
    );

    fifo_wr_arbiter #(.DATA_WD(DW), .NUM_REQ(NR), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .req(req2), .req_data(req_data), .gnt(gnt2),
        .wfull(1'b0), .winc(winc2), .wdata(wdata2), .busy(busy2), .owner(owner2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        #1 rst = 1'b1;
        #2;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_winc", 32'(winc), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_owner", 32'(owner), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Advance one clock; each requester moves to its next beat after a transfer.
    task automatic tick();
        logic [NR-1:0] xs;
        @(negedge clk);
        xs = req & gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (xs[i]) dat[i] = dat[i] + 8'd1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          do_rst;
        logic [NR-1:0] req;
        logic          wfull;
        logic [NR-1:0] gnt;
        logic          winc;
        logic [DW-1:0] wdata;
        logic          busy;
        logic [1:0]    owner;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [NR-1:0] q, input logic f,
                       input logic [NR-1:0] g, input logic w, input logic [DW-1:0] d,
                       input logic b, input logic [1:0] o);
        vec_t v;
        v.do_rst = r; v.req = q; v.wfull = f; v.gnt = g;
        v.winc = w; v.wdata = d; v.busy = b; v.owner = o;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    bit m_busy;
    int m_owner, m_start, m_left;

    function automatic logic [NR-1:0] m_gnt();
        logic [NR-1:0] g;
        g = '0;
        if (m_busy && req[m_owner] && !wfull) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_owner = 0; m_start = 0; m_left = 0;
    endtask

    task automatic m_step();
        bit done;
        done = 0;
        if (!m_busy) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_start + k) % NR;
                if (!done && req[j]) begin
                    done = 1; m_owner = j; m_left = BL; m_busy = 1;
                end
            end
        end else if (!req[m_owner]) begin
            m_busy = 0; m_start = (m_owner + 1) % NR;
        end else if (!wfull) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_start = (m_owner + 1) % NR;
            end
        end
    endtask

    initial begin
        dat[0] = 8'h30; dat[1] = 8'h20; dat[2] = 8'h10; dat[3] = 8'h40;
        @(posedge clk);
        do_reset();

        // Single requester 2: bubble, 4 beats, bubble, 4 beats.
        add(0, 4'b0100, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        for (int i = 0; i < 4; i++) add(0, 4'b0100, 0, 4'b0100, 1, 8'(8'h10 + i), 1, 2'd2);
        add(0, 4'b0100, 0, 4'b0000, 0, 8'h00, 0, 2'd2);
        for (int i = 0; i < 4; i++) add(0, 4'b0100, 0, 4'b0100, 1, 8'(8'h14 + i), 1, 2'd2);
        add(0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd2);
        // Owner 1 stalls on wfull for 3 cycles after 2 beats, then finishes 2 more.
        add(0, 4'b0010, 0, 4'b0000, 0, 8'h00, 0, 2'd2);
        add(0, 4'b0010, 0, 4'b0010, 1, 8'h20, 1, 2'd1);
        add(0, 4'b0010, 0, 4'b0010, 1, 8'h21, 1, 2'd1);
        for (int i = 0; i < 3; i++) add(0, 4'b0010, 1, 4'b0000, 0, 8'h00, 1, 2'd1);
        add(0, 4'b0010, 0, 4'b0010, 1, 8'h22, 1, 2'd1);
        add(0, 4'b0010, 0, 4'b0010, 1, 8'h23, 1, 2'd1);
        add(0, 4'b0010, 0, 4'b0000, 0, 8'h00, 0, 2'd1);
        // Owner 0 withdraws after 1 beat; requester 3 is next, skipping 1 and 2.
        add(1, 4'b1001, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        add(0, 4'b1001, 0, 4'b0001, 1, 8'h30, 1, 2'd0);
        add(0, 4'b1000, 0, 4'b0000, 0, 8'h00, 1, 2'd0);
        add(0, 4'b1000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        add(0, 4'b1000, 0, 4'b1000, 1, 8'h40, 1, 2'd3);

        foreach (tbl[n]) begin
            if (tbl[n].do_rst) begin
                req = '0;
                do_reset();
            end
            req   = tbl[n].req;
            wfull = tbl[n].wfull;
            #2;
            check("t_gnt", 32'(gnt), 32'(tbl[n].gnt));
            check("t_winc", 32'(winc), 32'(tbl[n].winc));
            check("t_busy", 32'(busy), 32'(tbl[n].busy));
            check("t_owner", 32'(owner), 32'(tbl[n].owner));
            if (tbl[n].winc) check("t_wdata", 32'(wdata), 32'(tbl[n].wdata));
            tick();
        end
        req = '0; wfull = 1'b0;

        // All four requesting: owners 0,1,2,3,0, 4 beats each, one bubble between.
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            #2;
            check("rr_winc", 32'(winc), 32'((c % 5) != 0));
            if ((c % 5) != 0) begin
                check("rr_owner", 32'(owner), 32'((c / 5) % 4));
                check("rr_gnt", 32'(gnt), 32'(1 << ((c / 5) % 4)));
            end
            tick();
        end

        // Reset in the middle of owner 2's burst.
        req = '0;
        do_reset();
        req = 4'b0100;
        #2;
        tick(); tick(); tick();
        check("mid_pre_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        check("mid_gnt", 32'(gnt), 32'(0));
        check("mid_winc", 32'(winc), 32'(0));
        check("mid_busy", 32'(busy), 32'(0));
        req = 4'b1111;
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("mid_idle_gnt", 32'(gnt), 32'(0));
        tick();
        #2;
        check("mid_first_gnt", 32'(gnt), 32'(4'b0001));
        check("mid_first_owner", 32'(owner), 32'(0));
        tick();

        // BURST_LEN=1 build alternating between requesters 1 and 3.
        req = '0;
        do_reset();
        req2 = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            #2;
            if (c % 2 == 0) begin
                check("b1_bubble_gnt", 32'(gnt2), 32'(0));
                check("b1_bubble_busy", 32'(busy2), 32'(0));
            end else begin
                check("b1_gnt", 32'(gnt2), 32'(((c / 2) % 2 == 0) ? 4'b0010 : 4'b1000));
                check("b1_winc", 32'(winc2), 32'(1));
                check("b1_owner", 32'(owner2), 32'(((c / 2) % 2 == 0) ? 1 : 3));
                check("b1_wdata", 32'(wdata2), 32'(dat[owner2]));
            end
            tick();
        end
        req2 = '0;

        // Randomized traffic against the model, with a write-data scoreboard.
        do_reset();
        m_reset();
        for (int c = 0; c < 600; c++) begin
            logic [NR-1:0] eg;
            for (int i = 0; i < NR; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                end
            end
            wfull = ($urandom_range(0, 3) == 0);
            #2;
            eg = m_gnt();
            check("r_gnt", 32'(gnt), 32'(eg));
            check("r_winc", 32'(winc), 32'(|eg));
            check("r_busy", 32'(busy), 32'(m_busy));
            check("r_owner", 32'(owner), 32'(m_owner));
            if (|eg) exp_q.push_back(dat[m_owner]);
            if (winc) begin
                if (exp_q.size() == 0) begin
                    check("r_sb_unexpected", 32'(1), 32'(0));
                end else begin
                    check("r_wdata", 32'(wdata), 32'(exp_q.pop_front()));
                end
            end
            m_step();
            tick();
        end
        check("r_sb_left", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
